ggt_core_param: RTL and testbench
=================================

Name: ggt_core_param

Overview:
- Parametrised successor to the fixed 16-bit ggT core.
- Computes gcd(Zahl1_i, Zahl2_i) of configurable WIDTH using one of two algorithms, selectable per operation:
  - subtractive Euclid
  - binary (Stein) algorithm
- Also reports an iteration count, a zero-operand flag and an abort path.
- Sits behind the existing start/valid handshake so the file-driven testbench and the board wrapper can drive it unchanged apart from mode_i and abort_i.

Parameters:
- WIDTH, 16, operand/result width in bits (>=2).
- CNT_W, WIDTH+1, width of the iteration counter cycles_o; must hold 2^WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- start_i  in  1  start request; sampled only in IDLE.
- mode_i  in  1  algorithm select, latched at start: 0 = subtractive Euclid, 1 = binary Stein.
- abort_i  in  1  synchronous abort; effective only in CALC.
- Zahl1_i  in  WIDTH  operand A, latched at start.
- Zahl2_i  in  WIDTH  operand B, latched at start.
- busy_o  out  1  high while in CALC.
- valid_o  out  1  one-cycle pulse: ergebnis_o, cycles_o and zero_o are valid.
- ergebnis_o  out  WIDTH  gcd result; held until the next valid_o.
- cycles_o  out  CNT_W  number of CALC cycles of the last completed operation; held.
- zero_o  out  1  set with valid_o when both operands were 0; held.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - State is IDLE.
  - busy_o, valid_o and zero_o are 0.
  - ergebnis_o and cycles_o are 0.
  - Internal a, b, k and the iteration counter are cleared.
- States: IDLE and CALC; valid_o is a registered output, not a separate state.
- IDLE:
  - On a clock edge with start_i=1: latch a<=Zahl1_i, b<=Zahl2_i, mode<=mode_i, k<=0, cnt<=0.
  - Next state is CALC and busy_o goes to 1.
  - start_i=0 keeps the block in IDLE.
- CALC, one step per edge, with cnt<=cnt+1 on every step. Checks are evaluated in this order:
  1. abort_i=1: go to IDLE, valid_o stays 0, outputs keep their previous values, cnt is discarded. Abort has priority over termination on the same edge.
  2. a==0 or b==0: terminate. ergebnis_o<=(a|b)<<k. zero_o<=(a==0 && b==0).
  3. a==b: terminate. ergebnis_o<=a<<k (k is always 0 in Euclid mode). zero_o<=0.
  4. Euclid step: if a>b then a<=a-b, else b<=b-a.
  5. Stein step:
     - a and b both even: a>>=1, b>>=1, k<=k+1.
     - else a even: a>>=1.
     - else b even: b>>=1.
     - else the larger operand is replaced by larger−smaller.
- Termination: on the terminating edge, valid_o<=1 for exactly one cycle, busy_o<=0, cycles_o<=cnt+1, and next state is IDLE.
- Latency:
  - valid_o is high in the cycle after edge E0+cycles_o, where E0 is the edge at which start was sampled.
  - A new start_i is accepted on the very edge where valid_o is high, i.e. in the first IDLE cycle.
- start_i in CALC is ignored and not queued.
- Changes to mode_i or the operands during CALC have no effect.
- Arithmetic:
  - All subtraction is unsigned WIDTH-bit, with the larger operand minus the smaller, so it never underflows.
  - The Stein result shift cannot overflow: gcd <= max operand.
  - k needs at most clog2(WIDTH)+1 bits.
- Worst case: Euclid gcd(2^WIDTH−1, 1) gives cycles_o = 2^WIDTH−1. CNT_W must not wrap for this case.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values.

Test Plan:
- Reset, then start with mode=0, Zahl1=12, Zahl2=8 -> valid_o pulses after E0+3, ergebnis_o=4, cycles_o=3, zero_o=0, busy_o high for exactly 3 cycles.
- mode=1, 12 and 8 -> ergebnis_o=4, cycles_o=6. Then mode=1, 48 and 18 -> ergebnis_o=6. Repeat 48/18 with mode=0 -> ergebnis_o=6, cycles_o=5.
- Zero cases, each with cycles_o=1:
  - 0 and 0 -> ergebnis_o=0, zero_o=1.
  - 0 and 35 -> ergebnis_o=35, zero_o=0.
  - 35 and 0 -> ergebnis_o=35, zero_o=0.
- Worst case with WIDTH=16, mode=0, 65535 and 1 -> ergebnis_o=1, cycles_o=65535, no counter wrap. Same inputs with mode=1 -> ergebnis_o=1, cycles_o well below 65535.
- Start with 1000 and 3, raise abort_i on the 5th CALC cycle -> no valid_o, busy_o low next cycle, ergebnis_o keeps the previous result. Then start with 9 and 6 -> ergebnis_o=3.
- Control edge cases:
  - Pulse start_i again during CALC with other operands -> ignored, the first result is reported.
  - Pull rst_ni low mid-CALC -> all outputs 0 immediately (asynchronously).
  - Back-to-back start on the valid_o cycle -> accepted.

Source files
------------

// File: rtl/ggt_core_param.sv
// GCD core with selectable subtractive-Euclid or binary (Stein) algorithm.
// Operands latched at start; one reduction step per cycle while busy.
module ggt_core_param #(
  parameter int WIDTH = 16,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] Zahl1_i,
  input  logic [WIDTH-1:0] Zahl2_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] ergebnis_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic             zero_o
);

  // state  | meaning
  // S_IDLE | waiting for start_i; results held
  // S_CALC | one Euclid/Stein step per edge until an operand is 0 or a==b
  localparam int K_W = $clog2(WIDTH) + 1;

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_mode;
  logic [K_W-1:0]   r_k;
  logic [CNT_W-1:0] r_cnt;

  logic             w_done;
  logic             w_zero;
  logic             w_a_gt;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_a_nxt, w_b_nxt;
  logic [K_W-1:0]   w_k_nxt;

  assign w_zero = (r_a == '0) && (r_b == '0);
  assign w_done = (r_a == '0) || (r_b == '0) || (r_a == r_b);
  assign w_a_gt = r_a > r_b;
  assign w_diff = w_a_gt ? (r_a - r_b) : (r_b - r_a);
  // a|b covers both the zero-operand case and a==b
  assign w_res  = (r_a | r_b) << r_k;

  always_comb begin
    w_a_nxt = r_a;
    w_b_nxt = r_b;
    w_k_nxt = r_k;
    if (!r_mode) begin
      if (w_a_gt) w_a_nxt = w_diff;
      else        w_b_nxt = w_diff;
    end else if (!r_a[0] && !r_b[0]) begin
      w_a_nxt = r_a >> 1;
      w_b_nxt = r_b >> 1;
      w_k_nxt = r_k + K_W'(1);
    end else if (!r_a[0]) begin
      w_a_nxt = r_a >> 1;
    end else if (!r_b[0]) begin
      w_b_nxt = r_b >> 1;
    end else if (w_a_gt) begin
      w_a_nxt = w_diff;
    end else begin
      w_b_nxt = w_diff;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_next = S_CALC;
      S_CALC: if (abort_i || w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (r_state == S_CALC);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a        <= '0;
      r_b        <= '0;
      r_mode     <= 1'b0;
      r_k        <= '0;
      r_cnt      <= '0;
      valid_o    <= 1'b0;
      ergebnis_o <= '0;
      cycles_o   <= '0;
      zero_o     <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start_i) begin
          r_a    <= Zahl1_i;
          r_b    <= Zahl2_i;
          r_mode <= mode_i;
          r_k    <= '0;
          r_cnt  <= '0;
        end
      end else if (!abort_i) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_done) begin
          valid_o    <= 1'b1;
          ergebnis_o <= w_res;
          cycles_o   <= r_cnt + CNT_W'(1);
          zero_o     <= w_zero;
        end else begin
          r_a <= w_a_nxt;
          r_b <= w_b_nxt;
          r_k <= w_k_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_ggt_core_param.sv
// Bench for ggt_core_param: cycle-level reference model plus directed operations
// with hand-computed results, latencies and control edge cases.
module tb_ggt_core_param;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i, mode_i, abort_i;
  logic [15:0] Zahl1_i, Zahl2_i;
  logic        busy_o, valid_o, zero_o;
  logic [15:0] ergebnis_o;
  logic [16:0] cycles_o;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  ggt_core_param #(.WIDTH(16), .CNT_W(17)) dut (
    .clk(clk), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
    .abort_i(abort_i), .Zahl1_i(Zahl1_i), .Zahl2_i(Zahl2_i),
    .busy_o(busy_o), .valid_o(valid_o), .ergebnis_o(ergebnis_o),
    .cycles_o(cycles_o), .zero_o(zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    int          cyc;
    logic        zero;
  } op_t;

  // Result from remainder-based gcd; cycle count from the algorithm rules.
  function automatic op_t model_op(input logic m, input logic [15:0] a0, input logic [15:0] b0);
    op_t r;
    int unsigned a, b, ga, gb, t;
    ga = a0; gb = b0;
    while (gb != 0) begin t = ga % gb; ga = gb; gb = t; end
    r.res  = ga[15:0];
    r.zero = (a0 == 0) && (b0 == 0);
    r.cyc  = 0;
    a = a0; b = b0;
    while (r.cyc < 70000) begin
      r.cyc++;
      if (a == 0 || b == 0 || a == b) break;
      if (!m) begin
        if (a > b) a = a - b; else b = b - a;
      end else if (a % 2 == 0 && b % 2 == 0) begin
        a = a / 2; b = b / 2;
      end else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0) b = b / 2;
      else if (a > b) a = a - b;
      else b = b - a;
    end
    return r;
  endfunction

  op_t         cur_op;
  op_t         pend;
  logic        m_busy, m_valid, m_zero;
  logic [15:0] m_res;
  int          m_cyc, m_rem;

  always_comb cur_op = model_op(mode_i, Zahl1_i, Zahl2_i);

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_zero <= 1'b0;
      m_res <= '0; m_cyc <= 0; m_rem <= 0;
    end else begin
      m_valid <= 1'b0;
      if (!m_busy) begin
        if (start_i) begin
          pend   <= cur_op;
          m_rem  <= cur_op.cyc;
          m_busy <= 1'b1;
        end
      end else if (abort_i) begin
        m_busy <= 1'b0;
      end else if (m_rem == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_res   <= pend.res;
        m_cyc   <= pend.cyc;
        m_zero  <= pend.zero;
      end else begin
        m_rem <= m_rem - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy_o", 32'(busy_o), 32'(m_busy));
      chk("valid_o", 32'(valid_o), 32'(m_valid));
      chk("ergebnis_o", 32'(ergebnis_o), 32'(m_res));
      chk("cycles_o", 32'(cycles_o), 32'(m_cyc));
      chk("zero_o", 32'(zero_o), 32'(m_zero));
    end
  end

  // Called at a negedge; returns at the negedge where valid_o is seen,
  // so consecutive calls exercise back-to-back starts.
  task automatic run_op(input string nm, input logic m, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input int ec, input logic ez);
    int lat, bcnt;
    mode_i = m; Zahl1_i = a; Zahl2_i = b; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; mode_i = ~m; Zahl1_i = 16'hA5A5; Zahl2_i = 16'h1234;
    lat = 1; bcnt = 0;
    while (!valid_o && lat < 70000) begin
      if (busy_o) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk({nm, " valid"}, 32'(valid_o), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'(ec + 1));
    chk({nm, " busy cycles"}, 32'(bcnt), 32'(ec));
    chk({nm, " result"}, 32'(ergebnis_o), 32'(er));
    chk({nm, " cycles"}, 32'(cycles_o), 32'(ec));
    chk({nm, " zero"}, 32'(zero_o), 32'(ez));
  endtask

  initial begin
    int w;
    rst_ni = 1'b0; start_i = 1'b0; mode_i = 1'b0; abort_i = 1'b0;
    Zahl1_i = '0; Zahl2_i = '0;
    #12;
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset valid", 32'(valid_o), 32'd0);
    chk("reset result", 32'(ergebnis_o), 32'd0);
    chk("reset cycles", 32'(cycles_o), 32'd0);
    chk("reset zero", 32'(zero_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    run_op("e12_8",  1'b0, 16'd12, 16'd8,  16'd4, 3, 1'b0);
    run_op("s12_8",  1'b1, 16'd12, 16'd8,  16'd4, 6, 1'b0);
    run_op("s48_18", 1'b1, 16'd48, 16'd18, 16'd6, 7, 1'b0);
    run_op("e48_18", 1'b0, 16'd48, 16'd18, 16'd6, 5, 1'b0);
    run_op("z0_0",   1'b0, 16'd0,  16'd0,  16'd0, 1, 1'b1);
    run_op("z0_35",  1'b0, 16'd0,  16'd35, 16'd35, 1, 1'b0);
    run_op("z35_0",  1'b1, 16'd35, 16'd0,  16'd35, 1, 1'b0);
    run_op("eworst", 1'b0, 16'd65535, 16'd1, 16'd1, 65535, 1'b0);
    run_op("sworst", 1'b1, 16'd65535, 16'd1, 16'd1, 31, 1'b0);

    // abort on the 5th CALC cycle
    mode_i = 1'b0; Zahl1_i = 16'd1000; Zahl2_i = 16'd3; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (4) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk); abort_i = 1'b0;
    chk("abort busy", 32'(busy_o), 32'd0);
    chk("abort valid", 32'(valid_o), 32'd0);
    chk("abort result kept", 32'(ergebnis_o), 32'd1);
    chk("abort cycles kept", 32'(cycles_o), 32'd31);
    repeat (3) @(negedge clk);
    run_op("e9_6", 1'b0, 16'd9, 16'd6, 16'd3, 3, 1'b0);

    // start pulse during CALC is ignored
    mode_i = 1'b0; Zahl1_i = 16'd48; Zahl2_i = 16'd18; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); start_i = 1'b1; mode_i = 1'b1; Zahl1_i = 16'd9; Zahl2_i = 16'd6;
    @(negedge clk); start_i = 1'b0;
    w = 0;
    while (!valid_o && w < 100) begin @(negedge clk); w++; end
    chk("ignored start valid", 32'(valid_o), 32'd1);
    chk("ignored start result", 32'(ergebnis_o), 32'd6);
    chk("ignored start cycles", 32'(cycles_o), 32'd5);

    // asynchronous reset in the middle of CALC
    run_op("z0_0b", 1'b0, 16'd0, 16'd0, 16'd0, 1, 1'b1);
    run_op("e12_8b", 1'b0, 16'd12, 16'd8, 16'd4, 3, 1'b0);
    mode_i = 1'b0; Zahl1_i = 16'd1000; Zahl2_i = 16'd3; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("midreset busy", 32'(busy_o), 32'd0);
    chk("midreset valid", 32'(valid_o), 32'd0);
    chk("midreset result", 32'(ergebnis_o), 32'd0);
    chk("midreset cycles", 32'(cycles_o), 32'd0);
    chk("midreset zero", 32'(zero_o), 32'd0);
    @(negedge clk); rst_ni = 1'b1;
    @(negedge clk);
    run_op("e9_6b", 1'b0, 16'd9, 16'd6, 16'd3, 3, 1'b0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
